// File: rtl/uart_rx_fifo.sv
// Parametrised UART receiver: oversampled start/data/parity/stop framing with
// error flags, feeding a show-ahead receive FIFO with sticky overrun.
module uart_rx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clock50,
    input  logic                          clear_n,
    input  logic                          tick,
    input  logic                          rx,
    input  logic                          rd_en,
    input  logic                          ovr_clr,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          rd_frame_err,
    output logic                          rd_parity_err,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overrun
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = DATA_BITS + 2;
    localparam logic [TW-1:0] T_HALF  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_LAST  = TW'(OVERSAMPLE - 1);
    localparam logic [3:0]    D_LAST  = 4'(DATA_BITS - 1);
    localparam logic [3:0]    S_LAST  = 4'(STOP_BITS - 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic          ODD_PAR = (PARITY == 2);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_PAR   = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    // A set result means the received parity bit disagrees with the data.
    function automatic logic parity_err(input logic [DATA_BITS-1:0] d, input logic pbit);
        return (^d) ^ pbit ^ ODD_PAR;
    endfunction

    logic                 rx_meta_r;
    logic                 rxs_r;
    logic [1:0]           sync_vld_r;
    logic                 armed_r;
    state_t               state_r;
    logic [TW-1:0]        tcnt_r;
    logic [3:0]           bcnt_r;
    logic [DATA_BITS-1:0] shreg_r;
    logic                 ferr_r;
    logic                 perr_r;

    logic [EW-1:0]        mem_r [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_r;
    logic [AW-1:0]        rd_ptr_r;
    logic [CW-1:0]        count_r;
    logic                 empty_r;
    logic                 full_r;
    logic                 overrun_r;
    logic [EW-1:0]        last_r;

    logic                 centre_s;
    logic                 push_s;
    logic [EW-1:0]        push_entry_s;
    logic                 do_pop_s;
    logic                 do_push_s;
    logic                 ovr_set_s;
    logic [CW-1:0]        count_nxt_s;
    logic [EW-1:0]        head_s;

    // Two-flop synchroniser; sync_vld_r masks the reset value until real line data arrives.
    always_ff @(posedge clock50 or negedge clear_n) begin
        if (!clear_n) begin
            rx_meta_r  <= 1'b1;
            rxs_r      <= 1'b1;
            sync_vld_r <= 2'b00;
        end else begin
            rx_meta_r  <= rx;
            rxs_r      <= rx_meta_r;
            sync_vld_r <= {sync_vld_r[0], 1'b1};
        end
    end

    // Push decode, FIFO occupancy arithmetic and show-ahead head selection.
    always_comb begin
        centre_s     = (tcnt_r == T_LAST);
        push_s       = tick && (state_r == S_STOP) && centre_s && (bcnt_r == S_LAST);
        push_entry_s = {ferr_r | ~rxs_r, perr_r, shreg_r};
        do_pop_s     = rd_en && !empty_r;
        do_push_s    = push_s && (!full_r || do_pop_s);
        ovr_set_s    = push_s && full_r && !do_pop_s;
        count_nxt_s  = count_r;
        if (do_push_s && !do_pop_s) begin
            count_nxt_s = count_r + CW'(1);
        end else if (!do_push_s && do_pop_s) begin
            count_nxt_s = count_r - CW'(1);
        end else begin
            count_nxt_s = count_r;
        end
        if (empty_r) begin
            head_s = last_r;
        end else begin
            head_s = mem_r[rd_ptr_r];
        end
    end

    // Frame FSM; after reset it stays disarmed until the line has been seen high.
    always_ff @(posedge clock50 or negedge clear_n) begin
        if (!clear_n) begin
            armed_r <= 1'b0;
            state_r <= S_IDLE;
            tcnt_r  <= '0;
            bcnt_r  <= 4'd0;
            shreg_r <= '0;
            ferr_r  <= 1'b0;
            perr_r  <= 1'b0;
        end else if (tick) begin
            if (rxs_r && sync_vld_r[1]) begin
                armed_r <= 1'b1;
            end
            case (state_r)
                S_IDLE: begin
                    if (!rxs_r && armed_r) begin
                        tcnt_r  <= '0;
                        state_r <= S_START;
                    end
                end
                S_START: begin
                    if (tcnt_r == T_HALF) begin
                        if (rxs_r) begin
                            state_r <= S_IDLE;
                        end else begin
                            tcnt_r  <= '0;
                            bcnt_r  <= 4'd0;
                            ferr_r  <= 1'b0;
                            perr_r  <= 1'b0;
                            state_r <= S_DATA;
                        end
                    end else begin
                        tcnt_r <= tcnt_r + TW'(1);
                    end
                end
                S_DATA: begin
                    if (centre_s) begin
                        shreg_r <= {rxs_r, shreg_r[DATA_BITS-1:1]};
                        tcnt_r  <= '0;
                        if (bcnt_r == D_LAST) begin
                            bcnt_r  <= 4'd0;
                            state_r <= (PARITY != 0) ? S_PAR : S_STOP;
                        end else begin
                            bcnt_r <= bcnt_r + 4'd1;
                        end
                    end else begin
                        tcnt_r <= tcnt_r + TW'(1);
                    end
                end
                S_PAR: begin
                    if (centre_s) begin
                        perr_r  <= parity_err(shreg_r, rxs_r);
                        tcnt_r  <= '0;
                        state_r <= S_STOP;
                    end else begin
                        tcnt_r <= tcnt_r + TW'(1);
                    end
                end
                S_STOP: begin
                    if (centre_s) begin
                        ferr_r <= ferr_r | ~rxs_r;
                        tcnt_r <= '0;
                        if (bcnt_r == S_LAST) begin
                            bcnt_r  <= 4'd0;
                            state_r <= S_IDLE;
                        end else begin
                            bcnt_r <= bcnt_r + 4'd1;
                        end
                    end else begin
                        tcnt_r <= tcnt_r + TW'(1);
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    // Receive FIFO; a push into a full FIFO only succeeds when a pop frees the head slot.
    always_ff @(posedge clock50 or negedge clear_n) begin
        if (!clear_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            count_r   <= '0;
            empty_r   <= 1'b1;
            full_r    <= 1'b0;
            overrun_r <= 1'b0;
            last_r    <= '0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_entry_s;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                last_r   <= mem_r[rd_ptr_r];
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_nxt_s;
            empty_r <= (count_nxt_s == CW'(0));
            full_r  <= (count_nxt_s == DEPTH_C);
            if (ovr_set_s) begin
                overrun_r <= 1'b1;
            end else if (ovr_clr) begin
                overrun_r <= 1'b0;
            end
        end
    end

    assign rd_data       = head_s[DATA_BITS-1:0];
    assign rd_parity_err = head_s[DATA_BITS];
    assign rd_frame_err  = head_s[DATA_BITS+1];
    assign empty         = empty_r;
    assign full          = full_r;
    assign count         = count_r;
    assign overrun       = overrun_r;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: an 8N1 instance and an 8E2 instance, driven from a
// bit-level serial sender and checked against a queue-based receive model.
module tb_uart_rx_fifo;

    logic       clock50 = 1'b0;
    logic       clear_n = 1'b0;
    logic       tick = 1'b0;
    logic       rx0 = 1'b1, rx1 = 1'b1;
    logic       rd_en0 = 1'b0, rd_en1 = 1'b0;
    logic       ovr_clr0 = 1'b0, ovr_clr1 = 1'b0;
    logic [7:0] rd_data0, rd_data1;
    logic       fe0, fe1, pe0, pe1, em0, em1, fu0, fu1, ov0, ov1;
    logic [2:0] cnt0, cnt1;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: entries are {frame_err, parity_err, data}.
    logic [9:0] q0[$];
    logic [9:0] q1[$];
    logic       ovr_m [2];
    logic [9:0] last_m [2];

    uart_rx_fifo #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut0 (
        .clock50(clock50), .clear_n(clear_n), .tick(tick), .rx(rx0), .rd_en(rd_en0),
        .ovr_clr(ovr_clr0), .rd_data(rd_data0), .rd_frame_err(fe0), .rd_parity_err(pe0),
        .empty(em0), .full(fu0), .count(cnt0), .overrun(ov0));

    uart_rx_fifo #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) dut1 (
        .clock50(clock50), .clear_n(clear_n), .tick(tick), .rx(rx1), .rd_en(rd_en1),
        .ovr_clr(ovr_clr1), .rd_data(rd_data1), .rd_frame_err(fe1), .rd_parity_err(pe1),
        .empty(em1), .full(fu1), .count(cnt1), .overrun(ov1));

    always #5 clock50 = ~clock50;

    // Oversampling tick: one clock in every four.
    int div_cnt = 0;
    always @(negedge clock50) begin
        div_cnt <= (div_cnt == 3) ? 0 : div_cnt + 1;
        tick    <= (div_cnt == 3);
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_tick();
        @(posedge clock50);
        while (!tick) @(posedge clock50);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) wait_tick();
    endtask

    task automatic drive(input int sel, input logic v);
        if (sel == 0) rx0 = v;
        else rx1 = v;
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        for (int i = 0; i < 2; i++) begin
            ovr_m[i]  = 1'b0;
            last_m[i] = 10'h000;
        end
    endtask

    // pp: 0 nothing, 1 rd_en on the push cycle, 2 ovr_clr on the push cycle.
    task automatic model_push(input int sel, input logic [7:0] d, input logic pbit,
                              input logic [1:0] stop_low, input int pp);
        logic fe, pe;
        logic [9:0] e;
        fe = (sel == 1) ? (stop_low != 2'b00) : stop_low[0];
        pe = (sel == 1) ? ((^d) ^ pbit) : 1'b0;
        e  = {fe, pe, d};
        if (pp == 2) ovr_m[sel] = 1'b0;
        if (sel == 0) begin
            if (pp == 1 && q0.size() > 0) last_m[0] = q0.pop_front();
            if (q0.size() < 4) q0.push_back(e);
            else ovr_m[0] = 1'b1;
        end else begin
            if (pp == 1 && q1.size() > 0) last_m[1] = q1.pop_front();
            if (q1.size() < 4) q1.push_back(e);
            else ovr_m[1] = 1'b1;
        end
    endtask

    task automatic send_frame(input int sel, input logic [7:0] d, input logic pbit,
                              input logic [1:0] stop_low, input int pp);
        int nstop;
        nstop = (sel == 1) ? 2 : 1;
        drive(sel, 1'b0);
        ticks(16);
        for (int i = 0; i < 8; i++) begin
            drive(sel, d[i]);
            ticks(16);
        end
        if (sel == 1) begin
            drive(sel, pbit);
            ticks(16);
        end
        for (int s = 0; s < nstop; s++) begin
            drive(sel, ~stop_low[s]);
            if (pp != 0 && s == nstop - 1) begin
                ticks(8);
                repeat (3) @(posedge clock50);
                #1;
                if (pp == 1) rd_en0 = 1'b1;
                else ovr_clr0 = 1'b1;
                @(posedge clock50);
                #1;
                rd_en0   = 1'b0;
                ovr_clr0 = 1'b0;
                ticks(7);
            end else begin
                ticks(16);
            end
        end
        drive(sel, 1'b1);
        ticks(20);
        model_push(sel, d, pbit, stop_low, pp);
    endtask

    task automatic check_dut(input int sel);
        logic [9:0] e;
        int sz;
        if (sel == 0) begin
            sz = q0.size();
            e  = (sz > 0) ? q0[0] : last_m[0];
            check("d0_rd_data", 32'(rd_data0), 32'(e[7:0]));
            check("d0_frame_err", 32'(fe0), 32'(e[9]));
            check("d0_parity_err", 32'(pe0), 32'(e[8]));
            check("d0_count", 32'(cnt0), 32'(sz));
            check("d0_empty", 32'(em0), 32'(sz == 0));
            check("d0_full", 32'(fu0), 32'(sz == 4));
            check("d0_overrun", 32'(ov0), 32'(ovr_m[0]));
        end else begin
            sz = q1.size();
            e  = (sz > 0) ? q1[0] : last_m[1];
            check("d1_rd_data", 32'(rd_data1), 32'(e[7:0]));
            check("d1_frame_err", 32'(fe1), 32'(e[9]));
            check("d1_parity_err", 32'(pe1), 32'(e[8]));
            check("d1_count", 32'(cnt1), 32'(sz));
            check("d1_empty", 32'(em1), 32'(sz == 0));
            check("d1_full", 32'(fu1), 32'(sz == 4));
            check("d1_overrun", 32'(ov1), 32'(ovr_m[1]));
        end
    endtask

    task automatic pop(input int sel);
        if (sel == 0) rd_en0 = 1'b1;
        else rd_en1 = 1'b1;
        @(posedge clock50);
        #1;
        rd_en0 = 1'b0;
        rd_en1 = 1'b0;
        if (sel == 0 && q0.size() > 0) last_m[0] = q0.pop_front();
        if (sel == 1 && q1.size() > 0) last_m[1] = q1.pop_front();
        check_dut(sel);
    endtask

    task automatic ovr_clear(input int sel);
        if (sel == 0) ovr_clr0 = 1'b1;
        else ovr_clr1 = 1'b1;
        @(posedge clock50);
        #1;
        ovr_clr0 = 1'b0;
        ovr_clr1 = 1'b0;
        ovr_m[sel] = 1'b0;
        check_dut(sel);
    endtask

    // Holds reset for three clocks, checking reset values while it is asserted.
    task automatic do_reset();
        clear_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clock50);
        #1;
        check_dut(0);
        check_dut(1);
        clear_n = 1'b1;
        ticks(2);
    endtask

    typedef struct {
        int         sel;
        logic [7:0] data;
        logic       pbit;
        logic [1:0] stop_low;
        logic [7:0] exp_data;
        logic       exp_fe;
        logic       exp_pe;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{0, 8'hA5, 1'b0, 2'b00, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{0, 8'h5A, 1'b0, 2'b01, 8'h5A, 1'b1, 1'b0};
        vecs[2] = '{0, 8'h11, 1'b0, 2'b00, 8'h11, 1'b0, 1'b0};
        vecs[3] = '{1, 8'h03, 1'b1, 2'b00, 8'h03, 1'b0, 1'b1};
        vecs[4] = '{1, 8'h03, 1'b0, 2'b00, 8'h03, 1'b0, 1'b0};
        vecs[5] = '{1, 8'h07, 1'b1, 2'b00, 8'h07, 1'b0, 1'b0};
        vecs[6] = '{1, 8'h80, 1'b1, 2'b10, 8'h80, 1'b1, 1'b0};
        vecs[7] = '{1, 8'hFE, 1'b0, 2'b01, 8'hFE, 1'b1, 1'b1};

        model_reset();
        do_reset();

        // Directed frames, one at a time.
        foreach (vecs[k]) begin
            send_frame(vecs[k].sel, vecs[k].data, vecs[k].pbit, vecs[k].stop_low, 0);
            if (vecs[k].sel == 0) begin
                check("vec_data", 32'(rd_data0), 32'(vecs[k].exp_data));
                check("vec_fe", 32'(fe0), 32'(vecs[k].exp_fe));
                check("vec_pe", 32'(pe0), 32'(vecs[k].exp_pe));
                check("vec_count", 32'(cnt0), 32'd1);
            end else begin
                check("vec_data", 32'(rd_data1), 32'(vecs[k].exp_data));
                check("vec_fe", 32'(fe1), 32'(vecs[k].exp_fe));
                check("vec_pe", 32'(pe1), 32'(vecs[k].exp_pe));
                check("vec_count", 32'(cnt1), 32'd1);
            end
            pop(vecs[k].sel);
        end

        // Glitch on the line shorter than half a bit.
        drive(0, 1'b0);
        ticks(4);
        drive(0, 1'b1);
        ticks(40);
        check("glitch_count", 32'(cnt0), 32'd0);
        check_dut(0);

        // Overrun: five frames into a four-entry FIFO.
        for (int k = 1; k <= 5; k++) send_frame(0, 8'(k), 1'b0, 2'b00, 0);
        check("ovr_full", 32'(fu0), 32'd1);
        check("ovr_flag", 32'(ov0), 32'd1);
        check("ovr_head", 32'(rd_data0), 32'h01);
        check_dut(0);
        ovr_clear(0);
        send_frame(0, 8'h06, 1'b0, 2'b00, 2);
        check("ovr_set_wins", 32'(ov0), 32'd1);
        ovr_clear(0);
        send_frame(0, 8'h07, 1'b0, 2'b00, 1);
        check("ovr_pop_push", 32'(ov0), 32'd0);
        check("ovr_pp_count", 32'(cnt0), 32'd4);
        check_dut(0);
        for (int k = 0; k < 4; k++) begin
            logic [7:0] exp_seq [4];
            exp_seq = '{8'h02, 8'h03, 8'h04, 8'h07};
            check("ovr_pop_seq", 32'(rd_data0), 32'(exp_seq[k]));
            pop(0);
        end
        check("empty_hold", 32'(rd_data0), 32'h07);
        pop(0);

        // Reset during bit 3 of 0xFF with two entries queued.
        send_frame(0, 8'h21, 1'b0, 2'b00, 0);
        send_frame(0, 8'h42, 1'b0, 2'b00, 0);
        check("rst_pre_count", 32'(cnt0), 32'd2);
        drive(0, 1'b0);
        ticks(16);
        drive(0, 1'b1);
        ticks(56);
        do_reset();
        ticks(100);
        check_dut(0);
        send_frame(0, 8'h3C, 1'b0, 2'b00, 0);
        check("rst_next_frame", 32'(rd_data0), 32'h3C);
        check_dut(0);
        pop(0);

        // Reset released while the line is still low must not start a frame.
        drive(0, 1'b0);
        drive(1, 1'b0);
        ticks(3);
        do_reset();
        ticks(40);
        drive(0, 1'b1);
        drive(1, 1'b1);
        ticks(220);
        check("low_rearm_count0", 32'(cnt0), 32'd0);
        check("low_rearm_count1", 32'(cnt1), 32'd0);

        // Randomised traffic against the model.
        for (int it = 0; it < 24; it++) begin
            int sel;
            int npop;
            logic [1:0] sl;
            sel = int'($urandom_range(0, 1));
            sl  = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            send_frame(sel, 8'($urandom), 1'($urandom), sl, 0);
            check_dut(sel);
            npop = int'($urandom_range(0, 2));
            for (int p = 0; p < npop; p++) pop(sel);
            if ($urandom_range(0, 4) == 0) ovr_clear(sel);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver for the MIPS32 platform's serial path. It replaces the fixed 8N1 receiver: data width, oversampling ratio, parity mode and stop-bit count are configurable. It also adds start-bit validation, framing/parity error detection and a show-ahead receive FIFO with overrun reporting. It sits between the baud tick generator and the memory-mapped UART register file, which pops words with `rd_en`.

## Interface
- `DATA_BITS`, 8: data bits per frame, legal 5..9.
- `OVERSAMPLE`, 16: ticks per bit, even, legal 8..32.
- `PARITY`, 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: legal 1 or 2.
- `FIFO_DEPTH`, 4: entries, power of two, at least 2.
- `clock50` input 1: system clock, all logic on the rising edge.
- `clear_n` input 1: asynchronous, active-low reset.
- `tick` input 1: one-cycle pulse at baud×`OVERSAMPLE`.
- `rx` input 1: asynchronous serial line, idle high.
- `rd_en` input 1: pop the head entry. Ignored when empty.
- `ovr_clr` input 1: clears `overrun`.
- `rd_data` output `DATA_BITS`: head entry data, show-ahead.
- `rd_frame_err` output 1: head entry had a bad stop bit.
- `rd_parity_err` output 1: head entry failed parity. Always 0 when `PARITY`=0.
- `empty` output 1: FIFO holds 0 entries.
- `full` output 1: FIFO holds `FIFO_DEPTH` entries.
- `count` output clog2(`FIFO_DEPTH`)+1: number of entries held.
- `overrun` output 1: sticky; a frame was dropped because the FIFO was full.

## Operation
- `rx` passes through a 2-flop synchroniser. The synchroniser resets to 1. All sampling uses the synchronised value `rxs`.
- `tcnt` is a tick counter with width clog2(`OVERSAMPLE`). `bcnt` is a bit counter. Both advance only on `tick`.
- FSM states are IDLE, START, DATA, PAR, STOP. Reset state is IDLE.
- IDLE: on a tick with `rxs`=0, load `tcnt`=0 and go to START.
- START: increment `tcnt` on each tick. At `tcnt`=`OVERSAMPLE`/2−1, sample `rxs`.
  - `rxs`=1: false start. Return to IDLE; nothing is pushed.
  - `rxs`=0: set `tcnt`=0, `bcnt`=0, go to DATA.
- DATA: on the tick where `tcnt`=`OVERSAMPLE`−1 (bit centre), do the following:
  - shift `rxs` into the shift register, LSB first;
  - increment `bcnt` and set `tcnt`=0;
  - after bit `DATA_BITS`−1, go to PAR if `PARITY`≠0, else STOP.
- PAR: sample at bit centre. `perr` = XOR of the data bits and the parity bit, inverted for odd parity; it must equal 0. Then go to STOP.
- STOP: sample `STOP_BITS` stop bits at their centres. `ferr` is set if any sampled stop bit is 0.
  - After the last stop sample, push {`ferr`, `perr`, data} and go directly to IDLE, without waiting out the rest of the stop bit.
  - In IDLE, a low `rxs` on a later tick starts the next frame (back-to-back frames).
- FIFO storage: circular buffer with read and write pointers, plus `count`. `rd_*` outputs show the entry at the read pointer combinationally. When empty, `rd_*` hold the last value.
- Push when not full: write the entry and increment the write pointer.
- Push when full:
  - without `rd_en`: the frame is dropped, `overrun` is set, and stored data is unchanged;
  - with `rd_en` in the same cycle: both the push and the pop occur, and `overrun` is not set.
- Push and pop in the same cycle when not empty: `count` is unchanged.
- Pop when empty: no effect.
- `overrun` clears on `ovr_clr`=1. If a set event and `ovr_clr` happen in the same cycle, the set wins.
- Pointers wrap modulo `FIFO_DEPTH`.
- `clear_n`=0 acts at any time, including mid-frame. It produces:
  - FSM in IDLE, all counters 0, shift register 0, FIFO emptied;
  - `empty`=1, `full`=0, `count`=0, `overrun`=0, `rd_data`=0, `rd_frame_err`=0, `rd_parity_err`=0.
  - A frame in progress at reset is discarded. After release, the receiver waits for the next falling edge. A line that is still low only re-arms the receiver after it returns high.

## Timing
- `rx` to `rxs` latency: 2 `clock50` cycles.
- A push is registered on the `clock50` edge of the final stop-sample tick. On the next cycle `empty` is 0 and `rd_data` is valid.
- `rd_en` is sampled on the rising edge. The next entry appears on the following cycle.
- `count`, `empty` and `full` are registered and reflect push/pop in the cycle after they occur.
- Start detection resolves to within one tick period. Sampling is mid-bit within ±1 tick.
- State only changes in a cycle with `tick`=1, except for FIFO pops, `ovr_clr` and reset.

## Test plan
- 8N1, `OVERSAMPLE`=16: send 0xA5 with 16 ticks per bit → one push. Then `rd_data`=0xA5, `rd_frame_err`=0, `rd_parity_err`=0, `count`=1.
- `PARITY`=1 (even): send 0x03 with parity bit 1 → `rd_parity_err`=1. Resend with parity 0 → `rd_parity_err`=0.
- Framing: send 0x5A with the stop bit held low → entry 0x5A pushed with `rd_frame_err`=1. The next frame 0x11 is received correctly.
- Glitch: pull `rx` low for 4 ticks, then release → no push, FSM back in IDLE, `count` stays 0.
- Overrun, `FIFO_DEPTH`=4: send 5 frames 0x01..0x05 with no pops → `full`=1, `overrun`=1, and pops return 0x01..0x04. A 6th frame arriving with a same-cycle `rd_en` is accepted without setting `overrun`. `ovr_clr` clears the flag.
- Reset mid-frame: assert `clear_n`=0 during bit 3 of 0xFF, with 2 entries already queued → all outputs take their reset values. The next frame 0x3C is received intact.
